// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add MULT, restoring DIV, HI/LO registers.
// Define MDU_SIGNED_EN to enable signed MULT/DIV (op[1]=1); otherwise op[1] is ignored.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic [WIDTH-1:0]   opd;      // multiplicand (MULT) or divisor (DIV)
    logic [WIDTH-1:0]   acc;      // product upper half / partial remainder
    logic [WIDTH-1:0]   lo_acc;   // multiplier shifting out / dividend->quotient

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   acc_n, lo_n;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   div_diff;

`ifdef MDU_SIGNED_EN
    logic               neg_res, neg_rem, sgn_div0;
    logic [WIDTH-1:0]   a_raw;
`else
    logic               unused_op_sign;
    assign unused_op_sign = op[1];
`endif

    // Operand magnitudes loaded into the datapath at start
    always_comb begin
        a_mag = a;
        b_mag = b;
`ifdef MDU_SIGNED_EN
        if (op[1] && a[WIDTH-1]) a_mag = -a;
        if (op[1] && b[WIDTH-1]) b_mag = -b;
`endif
    end

    // One radix-2 step: shift-add for multiply, restoring subtract for divide
    always_comb begin
        mul_sum  = {1'b0, acc} + (lo_acc[0] ? {1'b0, opd} : '0);
        rem_sh   = {acc, lo_acc[WIDTH-1]};
        div_diff = {1'b0, rem_sh} - {2'b00, opd};
        if (is_div) begin
            if (!div_diff[WIDTH+1]) begin
                acc_n = div_diff[WIDTH-1:0];
                lo_n  = {lo_acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = rem_sh[WIDTH-1:0];
                lo_n  = {lo_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_n = mul_sum[WIDTH:1];
            lo_n  = {mul_sum[0], lo_acc[WIDTH-1:1]};
        end
    end

    // Sign fix-up folded into the final write
    always_comb begin
        res_hi = acc_n;
        res_lo = lo_n;
`ifdef MDU_SIGNED_EN
        if (is_div) begin
            if (sgn_div0) begin
                res_hi = a_raw;
                res_lo = '1;
            end else begin
                if (neg_res) res_lo = -lo_n;
                if (neg_rem) res_hi = -acc_n;
            end
        end else if (neg_res) begin
            {res_hi, res_lo} = -{acc_n, lo_n};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            opd    <= '0;
            acc    <= '0;
            lo_acc <= '0;
`ifdef MDU_SIGNED_EN
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            sgn_div0 <= 1'b0;
            a_raw    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cnt    <= CNT_W'(WIDTH);
                        is_div <= op[0];
                        acc    <= '0;
                        if (op[0]) begin
                            opd    <= b_mag;
                            lo_acc <= a_mag;
                        end else begin
                            opd    <= a_mag;
                            lo_acc <= b_mag;
                        end
`ifdef MDU_SIGNED_EN
                        neg_res  <= op[1] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem  <= op[1] & a[WIDTH-1];
                        sgn_div0 <= op[1] & (b == '0);
                        a_raw    <= a;
`endif
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                RUN: begin
                    acc    <= acc_n;
                    lo_acc <= lo_n;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against an arithmetic reference model.
// Honours MDU_SIGNED_EN the same way as the design.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected {hi,lo} from MIPS arithmetic rules
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        logic   sgn;
        longint sa, sb;
        int     ia, ib, q, r;
        sgn = 1'b0;
`ifdef MDU_SIGNED_EN
        sgn = mop[1];
`endif
        if (!mop[0]) begin
            if (sgn) begin
                sa = longint'($signed(ma));
                sb = longint'($signed(mb));
                return 64'(sa * sb);
            end
            return {32'h0, ma} * {32'h0, mb};
        end
        if (mb == 32'h0) return {ma, 32'hFFFF_FFFF};
        if (sgn) begin
            if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            ia = $signed(ma);
            ib = $signed(mb);
            q  = ia / ib;
            r  = ia % ib;
            return {32'(r), 32'(q)};
        end
        return {ma % mb, ma / mb};
    endfunction

    // Runs one op from an idle cycle; returns #1 after the done edge.
    // With noise set, a stray start and MTHI/MTLO are driven mid-operation.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input bit noise);
        logic [63:0] exp;
        int          bad;
        exp   = model(o, x, y);
        bad   = 0;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < int'(W); i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            if (noise && i == 5) begin
                start = 1'b1; a = $urandom; b = $urandom;
                hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom;
            end else if (noise && i == 6) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(posedge clk);
        end
        #1;
        chk({tag, "_busy_run"}, 64'(bad), 64'd0);
        chk({tag, "_done"}, {62'd0, busy, done}, 64'd1);
        chk({tag, "_hilo"}, {hi, lo}, exp);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("idle_done_low", {63'd0, done}, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, hi, lo}, 66'd0);
        rst = 1'b0;
        idle_cycle();

        do_op("multu_15x10", 2'b00, 32'd15, 32'd10, 1'b0);
        chk("multu_15x10_lo", {32'd0, lo}, 64'd150);
        idle_cycle();

        do_op("divu_13_8", 2'b01, 32'd13, 32'd8, 1'b1);
        chk("divu_13_8_const", {hi, lo}, {32'd5, 32'd1});
        do_op("divu_8_13_b2b", 2'b01, 32'd8, 32'd13, 1'b0);
        chk("divu_8_13_const", {hi, lo}, {32'd8, 32'd0});
        idle_cycle();

        do_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("multu_max_const", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
        do_op("divu_by0", 2'b01, 32'd7, 32'd0, 1'b0);
        chk("divu_by0_const", {hi, lo}, {32'd7, 32'hFFFF_FFFF});
        idle_cycle();

        // MTHI/MTLO while idle
        hi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h5A5A_5A5A;
        chk("mthi_idle", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
        @(posedge clk); #1;
        lo_we = 1'b0;
        chk("mtlo_idle", {hi, lo}, {32'hA5A5_A5A5, 32'h5A5A_5A5A});
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo_both", {hi, lo}, {32'h1234_5678, 32'h1234_5678});
        repeat (3) @(posedge clk);
        #1;
        chk("hilo_hold", {hi, lo}, {32'h1234_5678, 32'h1234_5678});

        do_op("div_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef MDU_SIGNED_EN
        chk("div_m7_2_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
`else
        chk("div_m7_2_const", {hi, lo}, {32'd1, 32'h7FFF_FFFC});
`endif
        do_op("mult_m3_5", 2'b10, 32'hFFFF_FFFD, 32'd5, 1'b0);
        do_op("div_minneg", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op("div_sgn_by0", 2'b11, 32'hFFFF_FFF0, 32'd0, 1'b0);
        idle_cycle();

        for (int i = 0; i < 24; i++) begin
            do_op("rand", 2'($urandom_range(0, 3)), pick(), pick(), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        // Reset mid-operation: start at cycle 0, ignored start/MTHI at 5, reset at 10
        start = 1'b1; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; hi_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        chk("busy_before_rst", {63'd0, busy}, 64'd1);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_state", {busy, done, hi, lo}, 66'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("rst_mid_no_done", 64'(seen), 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
